// File: rtl/rf_access_arbiter_if.sv
// Requester-side access channel: request handshake plus registered read response.
interface rf_access_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// Register-file front end: zero-fills the RF after reset, then round-robins the
// single write port and the single read port independently between A and B.
module rf_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  rf_access_arbiter_if.slave    a,
  rf_access_arbiter_if.slave    b,
  output logic                  init_done,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wa,
  output logic [DATA_WIDTH-1:0] rf_wd,
  output logic [ADDR_WIDTH-1:0] rf_ra,
  input  logic [DATA_WIDTH-1:0] rf_rd
);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   init_cnt;
  logic                  wr_ptr, rd_ptr;  // 0: A has priority, 1: B
  logic                  wr_cand_a, wr_cand_b, rd_cand_a, rd_cand_b;
  logic                  wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    state_nxt   = state;
    wr_cand_a   = 1'b0;
    wr_cand_b   = 1'b0;
    rd_cand_a   = 1'b0;
    rd_cand_b   = 1'b0;
    wr_gnt_a    = 1'b0;
    wr_gnt_b    = 1'b0;
    rd_gnt_a    = 1'b0;
    rd_gnt_b    = 1'b0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    rf_ra       = '0;
    rd_data     = rf_rd;
    a.req_ready = 1'b0;
    b.req_ready = 1'b0;
    case (state)
      INIT: begin
        rf_we = 1'b1;
        rf_wa = init_cnt[ADDR_WIDTH-1:0];
        if (init_cnt == LAST) state_nxt = RUN;
      end
      RUN: begin
        wr_cand_a = a.req_valid &  a.req_we;
        wr_cand_b = b.req_valid &  b.req_we;
        rd_cand_a = a.req_valid & ~a.req_we;
        rd_cand_b = b.req_valid & ~b.req_we;
        wr_gnt_a  = wr_cand_a & (~wr_cand_b | ~wr_ptr);
        wr_gnt_b  = wr_cand_b & (~wr_cand_a |  wr_ptr);
        rd_gnt_a  = rd_cand_a & (~rd_cand_b | ~rd_ptr);
        rd_gnt_b  = rd_cand_b & (~rd_cand_a |  rd_ptr);
        rf_we     = wr_gnt_a | wr_gnt_b;
        if (wr_gnt_a) begin
          rf_wa = a.req_addr;
          rf_wd = a.req_wdata;
        end else if (wr_gnt_b) begin
          rf_wa = b.req_addr;
          rf_wd = b.req_wdata;
        end
        if (rd_gnt_a)      rf_ra = a.req_addr;
        else if (rd_gnt_b) rf_ra = b.req_addr;
        // Same-cycle write to the read address: return the new value.
        if (rf_we && (rd_gnt_a || rd_gnt_b) && rf_ra == rf_wa) rd_data = rf_wd;
        a.req_ready = wr_gnt_a | rd_gnt_a;
        b.req_ready = wr_gnt_b | rd_gnt_b;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= INIT;
      init_cnt    <= '0;
      init_done   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      a.rsp_valid <= 1'b0;
      a.rsp_rdata <= '0;
      b.rsp_valid <= 1'b0;
      b.rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == RUN);
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      if (wr_gnt_a)      wr_ptr <= 1'b1;
      else if (wr_gnt_b) wr_ptr <= 1'b0;
      if (rd_gnt_a)      rd_ptr <= 1'b1;
      else if (rd_gnt_b) rd_ptr <= 1'b0;
      a.rsp_valid <= rd_gnt_a;
      b.rsp_valid <= rd_gnt_b;
      if (rd_gnt_a) a.rsp_rdata <= rd_data;
      if (rd_gnt_b) b.rsp_rdata <= rd_data;
    end
  end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural RF and a response scoreboard.
module tb_rf_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          init_done, rf_we;
  logic [AW-1:0] rf_wa, rf_ra;
  logic [DW-1:0] rf_wd, rf_rd;
  logic [DW-1:0] mem [2**AW];

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  rf_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia ();
  rf_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib ();

  rf_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .a(ia), .b(ib), .init_done(init_done),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_rd(rf_rd)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read, garbage at power-up.
  initial for (int i = 0; i < 2**AW; i++) mem[i] = 32'hDEAD0000 | i;
  always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wd;
  assign rf_rd = mem[rf_ra];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    ia.req_valid = v; ia.req_we = we; ia.req_addr = ad; ia.req_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    ib.req_valid = v; ib.req_we = we; ib.req_addr = ad; ib.req_wdata = wd;
  endtask

  // Zero-fill window: exactly 32 write cycles, nothing granted, then init_done.
  task automatic init_seq();
    for (int i = 0; i < 2**AW; i++) begin
      @(negedge clk);
      chk("init_we", rf_we, 1);
      chk("init_wa", rf_wa, i);
      chk("init_wd", rf_wd, 0);
      chk("init_rdy_a", ia.req_ready, 0);
      chk("init_rdy_b", ib.req_ready, 0);
      chk("init_done_lo", init_done, 0);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) if (rstn) begin
    if (ia.rsp_valid) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_rsp_unexpected act=%0h exp=none", ia.rsp_rdata);
      end else chk("a_rsp", ia.rsp_rdata, qa.pop_front());
    end
    if (ib.rsp_valid) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_rsp_unexpected act=%0h exp=none", ib.rsp_rdata);
      end else chk("b_rsp", ib.rsp_rdata, qb.pop_front());
    end
  end

  logic [DW-1:0] a_d, b_d;
  logic [3:0]    exp_a_win;
  logic [DW-1:0] exp_wd [4];
  logic [AW-1:0] exp_wa [4];

  initial begin
    rstn = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_rsp_valid", ia.rsp_valid, 0);
    chk("rst_b_rsp_valid", ib.rsp_valid, 0);
    chk("rst_a_rsp_rdata", ia.rsp_rdata, 0);
    chk("rst_init_done", init_done, 0);
    rstn = 1'b1;

    // 1: zero-fill then read addr 7
    init_seq();
    @(negedge clk);
    chk("run_init_done", init_done, 1);
    chk("run_idle_we", rf_we, 0);
    cyc(); set_a(1, 0, 7, 0); qa.push_back(0);
    @(negedge clk);
    chk("t1_rdy_a", ia.req_ready, 1);
    chk("t1_ra", rf_ra, 7);

    // 2: A writes 3, B reads it back
    cyc(); set_a(1, 1, 3, 32'hA5);
    @(negedge clk);
    chk("t2_rdy_a", ia.req_ready, 1);
    chk("t2_we", rf_we, 1);
    chk("t2_wa", rf_wa, 3);
    chk("t2_wd", rf_wd, 32'hA5);
    cyc(); set_a(0, 0, 0, 0); set_b(1, 0, 3, 0); qb.push_back(32'hA5);
    @(negedge clk);
    chk("t2_rdy_b", ib.req_ready, 1);
    chk("t2_ra", rf_ra, 3);
    chk("t2_no_we", rf_we, 0);

    // Lone B write so write priority returns to A
    cyc(); set_b(1, 1, 10, 32'h10);
    @(negedge clk);
    chk("pre3_rdy_b", ib.req_ready, 1);

    // 3: both write every cycle; winners alternate A,B,A,B
    exp_a_win = 4'b0101;
    exp_wd[0] = 32'h100; exp_wd[1] = 32'h200; exp_wd[2] = 32'h101; exp_wd[3] = 32'h201;
    exp_wa[0] = 1; exp_wa[1] = 2; exp_wa[2] = 1; exp_wa[3] = 2;
    a_d = 32'h100; b_d = 32'h200;
    for (int k = 0; k < 4; k++) begin
      cyc(); set_a(1, 1, 1, a_d); set_b(1, 1, 2, b_d);
      @(negedge clk);
      chk("t3_rdy_a", ia.req_ready, exp_a_win[k]);
      chk("t3_rdy_b", ib.req_ready, !exp_a_win[k]);
      chk("t3_wa", rf_wa, exp_wa[k]);
      chk("t3_wd", rf_wd, exp_wd[k]);
      if (exp_a_win[k]) a_d++; else b_d++;
    end
    // Read both back: read priority is with A, B waits one cycle
    cyc(); set_a(1, 0, 1, 0); set_b(1, 0, 2, 0); qa.push_back(32'h101);
    @(negedge clk);
    chk("t3r_rdy_a", ia.req_ready, 1);
    chk("t3r_rdy_b", ib.req_ready, 0);
    chk("t3r_ra", rf_ra, 1);
    cyc(); set_a(0, 0, 0, 0); qb.push_back(32'h201);
    @(negedge clk);
    chk("t3r_rdy_b2", ib.req_ready, 1);
    chk("t3r_ra2", rf_ra, 2);

    // 4: write/read same address same cycle -> bypass
    cyc(); set_a(1, 1, 5, 32'h1234); set_b(1, 0, 5, 0); qb.push_back(32'h1234);
    @(negedge clk);
    chk("t4_rdy_a", ia.req_ready, 1);
    chk("t4_rdy_b", ib.req_ready, 1);

    // 6: write 9, read it, reset while the response is showing
    cyc(); set_b(0, 0, 0, 0); set_a(1, 1, 9, 32'hFF);
    @(negedge clk);
    chk("t6_rdy_a", ia.req_ready, 1);
    cyc(); set_a(0, 0, 0, 0); set_b(1, 0, 9, 0);
    @(negedge clk);
    chk("t6_rdy_b", ib.req_ready, 1);
    cyc();
    chk("t6_rsp_valid_pre", ib.rsp_valid, 1);
    chk("t6_rsp_rdata_pre", ib.rsp_rdata, 32'hFF);
    rstn = 1'b0;
    // 5: requests held across INIT
    set_a(1, 1, 20, 32'h77);
    set_b(1, 0, 9, 0);
    #1;
    chk("t6_rsp_valid_clr", ib.rsp_valid, 0);
    chk("t6_rsp_rdata_clr", ib.rsp_rdata, 0);
    chk("t6_init_done_clr", init_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    init_seq();
    @(negedge clk);
    chk("t5_rdy_a", ia.req_ready, 1);
    chk("t5_rdy_b", ib.req_ready, 1);
    chk("t5_wa", rf_wa, 20);
    chk("t5_wd", rf_wd, 32'h77);
    chk("t5_ra", rf_ra, 9);
    qb.push_back(0);
    cyc(); set_b(0, 0, 0, 0); set_a(1, 0, 20, 0); qa.push_back(32'h77);
    @(negedge clk);
    chk("t5r_rdy_a", ia.req_ready, 1);
    cyc(); set_a(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
